// File: rtl/id_decode_core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_types (package)
// Purpose  : Shared RV32I decode types: opcodes, ALU/branch operation codes,
//            datapath mux selects and the control word carried to ID/EX.
// Revision : 1.0 - initial release
// ============================================================================
package rv32i_types;

    typedef enum logic [6:0] {
        OP_LUI   = 7'b0110111,
        OP_AUIPC = 7'b0010111,
        OP_JAL   = 7'b1101111,
        OP_JALR  = 7'b1100111,
        OP_BR    = 7'b1100011,
        OP_LOAD  = 7'b0000011,
        OP_STORE = 7'b0100011,
        OP_IMM   = 7'b0010011,
        OP_REG   = 7'b0110011,
        OP_CSR   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0, ALU_SLL = 3'd1, ALU_SRA = 3'd2, ALU_SUB = 3'd3,
        ALU_XOR = 3'd4, ALU_SRL = 3'd5, ALU_OR  = 3'd6, ALU_AND = 3'd7
    } alu_ops;

    typedef enum logic [2:0] {
        BR_BEQ = 3'd0, BR_BNE = 3'd1, BR_BLT = 3'd4,
        BR_BGE = 3'd5, BR_BLTU = 3'd6, BR_BGEU = 3'd7
    } branch_funct3_t;

    typedef enum logic [1:0] {
        PCMUX_PC_PLUS4 = 2'd0, PCMUX_ALU_OUT = 2'd1, PCMUX_ALU_MOD2 = 2'd2
    } pcmux_sel_t;

    typedef enum logic {
        ALUMUX1_RS1_OUT = 1'b0, ALUMUX1_PC_OUT = 1'b1
    } alumux1_sel_t;

    typedef enum logic [2:0] {
        ALUMUX2_I_IMM = 3'd0, ALUMUX2_U_IMM = 3'd1, ALUMUX2_B_IMM = 3'd2,
        ALUMUX2_S_IMM = 3'd3, ALUMUX2_J_IMM = 3'd4, ALUMUX2_RS2_OUT = 3'd5
    } alumux2_sel_t;

    typedef enum logic [3:0] {
        RFMUX_ALU_OUT = 4'd0, RFMUX_BR_EN = 4'd1, RFMUX_U_IMM = 4'd2,
        RFMUX_LW = 4'd3, RFMUX_PC_PLUS4 = 4'd4, RFMUX_LB = 4'd5,
        RFMUX_LBU = 4'd6, RFMUX_LH = 4'd7, RFMUX_LHU = 4'd8
    } regfilemux_sel_t;

    typedef enum logic {
        CMPMUX_RS2_OUT = 1'b0, CMPMUX_I_IMM = 1'b1
    } cmpmux_sel_t;

    // opcode and cmpop carry raw instruction bits (unknown opcodes, funct3
    // 010/011) so they are plain vectors rather than enums.
    typedef struct packed {
        logic [6:0]      opcode;
        alu_ops          aluop;
        logic [2:0]      cmpop;
        pcmux_sel_t      pcmux_sel;
        alumux1_sel_t    alumux1_sel;
        alumux2_sel_t    alumux2_sel;
        regfilemux_sel_t regfilemux_sel;
        cmpmux_sel_t     cmpmux_sel;
        logic            load_regfile;
        logic            mem_read;
        logic            mem_write;
        logic [3:0]      mem_byte_en;
    } rv32i_control_word;

endpackage
`default_nettype wire

// File: rtl/id_decode_core_if.sv
`default_nettype none
// ============================================================================
// Module   : id_decode_core_if
// Purpose  : ID-stage bus: instruction + WB write port in, control word,
//            operands, immediates, register indices and br_en out.
//            slave = decode core, master = surrounding pipeline.
// Revision : 1.0 - initial release
// ============================================================================
interface id_decode_core_if;
    logic [31:0]                    instr_i;
    logic                           load_regfile_i;
    logic [4:0]                     rd_wr_i;
    logic [31:0]                    wr_data_i;
    rv32i_types::rv32i_control_word ctrl_word_o;
    logic [31:0]                    rs1_out_o, rs2_out_o;
    logic [31:0]                    i_imm_o, s_imm_o, b_imm_o, u_imm_o, j_imm_o;
    logic [4:0]                     rs1_o, rs2_o, rd_o;
    logic                           br_en_o;

    modport slave (
        input  instr_i, load_regfile_i, rd_wr_i, wr_data_i,
        output ctrl_word_o, rs1_out_o, rs2_out_o, i_imm_o, s_imm_o, b_imm_o,
               u_imm_o, j_imm_o, rs1_o, rs2_o, rd_o, br_en_o
    );

    modport master (
        output instr_i, load_regfile_i, rd_wr_i, wr_data_i,
        input  ctrl_word_o, rs1_out_o, rs2_out_o, i_imm_o, s_imm_o, b_imm_o,
               u_imm_o, j_imm_o, rs1_o, rs2_o, rd_o, br_en_o
    );
endinterface
`default_nettype wire

// File: rtl/id_decode_core_cmp.sv
`default_nettype none
// ============================================================================
// Module   : id_decode_core_cmp
// Purpose  : Branch / set-less-than comparator selected by a funct3 code.
// Ports    : i_cmpop, i_a, i_b in; o_br_en out
// Revision : 1.0 - initial release
// ============================================================================
module id_decode_core_cmp
    import rv32i_types::*;
#(
    parameter int WIDTH = 32
) (
    input  wire [2:0]       i_cmpop,
    input  wire [WIDTH-1:0] i_a,
    input  wire [WIDTH-1:0] i_b,
    output logic            o_br_en
);
    always_comb begin
        o_br_en = 1'b0;
        case (i_cmpop)
            BR_BEQ:  o_br_en = (i_a == i_b);
            BR_BNE:  o_br_en = (i_a != i_b);
            BR_BLT:  o_br_en = ($signed(i_a) <  $signed(i_b));
            BR_BGE:  o_br_en = ($signed(i_a) >= $signed(i_b));
            BR_BLTU: o_br_en = (i_a <  i_b);
            BR_BGEU: o_br_en = (i_a >= i_b);
            default: o_br_en = 1'b0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/id_decode_core_control_rom.sv
`default_nettype none
// ============================================================================
// Module   : id_decode_core_control_rom
// Purpose  : Combinational RV32I control decode from opcode/funct3/funct7[5].
// Ports    : i_opcode, i_funct3, i_funct7_b5 in; o_ctrl control word out
// Revision : 1.0 - initial release
// ============================================================================
module id_decode_core_control_rom
    import rv32i_types::*;
(
    input  wire [6:0]         i_opcode,
    input  wire [2:0]         i_funct3,
    input  wire               i_funct7_b5,
    output rv32i_control_word o_ctrl
);
    always_comb begin
        o_ctrl        = '0;
        o_ctrl.opcode = i_opcode;
        o_ctrl.aluop  = alu_ops'(i_funct3);
        o_ctrl.cmpop  = i_funct3;
        case (i_opcode)
            OP_LUI: begin
                o_ctrl.load_regfile   = 1'b1;
                o_ctrl.regfilemux_sel = RFMUX_U_IMM;
            end
            OP_AUIPC: begin
                o_ctrl.alumux1_sel  = ALUMUX1_PC_OUT;
                o_ctrl.alumux2_sel  = ALUMUX2_U_IMM;
                o_ctrl.aluop        = ALU_ADD;
                o_ctrl.load_regfile = 1'b1;
            end
            OP_JAL: begin
                o_ctrl.alumux1_sel    = ALUMUX1_PC_OUT;
                o_ctrl.alumux2_sel    = ALUMUX2_J_IMM;
                o_ctrl.aluop          = ALU_ADD;
                o_ctrl.pcmux_sel      = PCMUX_ALU_OUT;
                o_ctrl.regfilemux_sel = RFMUX_PC_PLUS4;
                o_ctrl.load_regfile   = 1'b1;
            end
            OP_JALR: begin
                o_ctrl.alumux2_sel    = ALUMUX2_I_IMM;
                o_ctrl.aluop          = ALU_ADD;
                o_ctrl.pcmux_sel      = PCMUX_ALU_MOD2;
                o_ctrl.regfilemux_sel = RFMUX_PC_PLUS4;
                o_ctrl.load_regfile   = 1'b1;
            end
            // Branch target is computed here; the redirect decision is taken
            // downstream from br_en, so pcmux stays at pc_plus4.
            OP_BR: begin
                o_ctrl.alumux1_sel = ALUMUX1_PC_OUT;
                o_ctrl.alumux2_sel = ALUMUX2_B_IMM;
                o_ctrl.aluop       = ALU_ADD;
                o_ctrl.cmpmux_sel  = CMPMUX_RS2_OUT;
            end
            OP_LOAD: begin
                o_ctrl.alumux2_sel  = ALUMUX2_I_IMM;
                o_ctrl.aluop        = ALU_ADD;
                o_ctrl.mem_read     = 1'b1;
                o_ctrl.load_regfile = 1'b1;
                case (i_funct3)
                    3'b000:  o_ctrl.regfilemux_sel = RFMUX_LB;
                    3'b001:  o_ctrl.regfilemux_sel = RFMUX_LH;
                    3'b010:  o_ctrl.regfilemux_sel = RFMUX_LW;
                    3'b100:  o_ctrl.regfilemux_sel = RFMUX_LBU;
                    3'b101:  o_ctrl.regfilemux_sel = RFMUX_LHU;
                    default: o_ctrl.regfilemux_sel = RFMUX_ALU_OUT;
                endcase
            end
            // Byte enables are unshifted; MEM aligns them to the address.
            OP_STORE: begin
                o_ctrl.alumux2_sel = ALUMUX2_S_IMM;
                o_ctrl.aluop       = ALU_ADD;
                o_ctrl.mem_write   = 1'b1;
                case (i_funct3)
                    3'b000:  o_ctrl.mem_byte_en = 4'b0001;
                    3'b001:  o_ctrl.mem_byte_en = 4'b0011;
                    3'b010:  o_ctrl.mem_byte_en = 4'b1111;
                    default: o_ctrl.mem_byte_en = 4'b0000;
                endcase
            end
            OP_IMM, OP_REG: begin
                o_ctrl.load_regfile = 1'b1;
                o_ctrl.alumux2_sel  = (i_opcode == OP_IMM) ? ALUMUX2_I_IMM : ALUMUX2_RS2_OUT;
                // slt*/sltu* go through the comparator, not the ALU.
                o_ctrl.cmpmux_sel   = (i_opcode == OP_IMM) ? CMPMUX_I_IMM : CMPMUX_RS2_OUT;
                case (i_funct3)
                    3'b000: begin
                        if (i_opcode == OP_REG && i_funct7_b5) o_ctrl.aluop = ALU_SUB;
                        else                                  o_ctrl.aluop = ALU_ADD;
                        o_ctrl.cmpmux_sel = CMPMUX_RS2_OUT;
                    end
                    3'b010: begin
                        o_ctrl.cmpop          = BR_BLT;
                        o_ctrl.regfilemux_sel = RFMUX_BR_EN;
                    end
                    3'b011: begin
                        o_ctrl.cmpop          = BR_BLTU;
                        o_ctrl.regfilemux_sel = RFMUX_BR_EN;
                    end
                    3'b101: begin
                        if (i_funct7_b5) o_ctrl.aluop = ALU_SRA;
                        else             o_ctrl.aluop = ALU_SRL;
                        o_ctrl.cmpmux_sel = CMPMUX_RS2_OUT;
                    end
                    default: o_ctrl.cmpmux_sel = CMPMUX_RS2_OUT;
                endcase
            end
            // CSR and unrecognised opcodes decode as a NOP.
            default: o_ctrl.aluop = ALU_ADD;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/id_decode_core_regfile.sv
`default_nettype none
// ============================================================================
// Module   : id_decode_core_regfile
// Purpose  : 32 x WIDTH register file, async active-low clear, one write
//            port, two combinational read ports with write-through.
// Ports    : clk, rst, i_load/i_rd/i_wr_data (write), i_rs1/i_rs2 (read
//            index), o_rs1_data/o_rs2_data (read data)
// Revision : 1.0 - initial release
// ============================================================================
module id_decode_core_regfile #(
    parameter int WIDTH = 32
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              i_load,
    input  wire [4:0]        i_rd,
    input  wire [WIDTH-1:0]  i_wr_data,
    input  wire [4:0]        i_rs1,
    input  wire [4:0]        i_rs2,
    output logic [WIDTH-1:0] o_rs1_data,
    output logic [WIDTH-1:0] o_rs2_data
);
    logic [WIDTH-1:0] r_regs [32];
    logic             w_wr_en;

    assign w_wr_en = i_load && (i_rd != 5'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[i_rd] <= i_wr_data;
        end
    end

    // A write in flight is forwarded so ID sees WB's result this cycle.
    always_comb begin
        o_rs1_data = r_regs[i_rs1];
        o_rs2_data = r_regs[i_rs2];
        if (w_wr_en && (i_rd == i_rs1)) o_rs1_data = i_wr_data;
        if (w_wr_en && (i_rd == i_rs2)) o_rs2_data = i_wr_data;
        if (i_rs1 == 5'd0) o_rs1_data = '0;
        if (i_rs2 == 5'd0) o_rs2_data = '0;
    end
endmodule
`default_nettype wire

// File: rtl/id_decode_core.sv
`default_nettype none
// ============================================================================
// Module   : id_decode_core
// Purpose  : ID-stage decode core: register file, control ROM, immediate
//            generation and branch comparator. Only the regfile is clocked.
// Ports    : clk, rst (async, active-low), bus (id_decode_core_if.slave)
// Revision : 1.0 - initial release
// ============================================================================
module id_decode_core
    import rv32i_types::*;
#(
    parameter int WIDTH = 32    // only 32 is supported
) (
    input  wire             clk,
    input  wire             rst,
    id_decode_core_if.slave bus
);
    logic [WIDTH-1:0]  w_instr;
    logic [WIDTH-1:0]  w_rs1_data, w_rs2_data, w_i_imm, w_cmp_b;
    rv32i_control_word w_ctrl;
    logic              w_br_en;

    assign w_instr = bus.instr_i;
    assign w_i_imm = {{20{w_instr[31]}}, w_instr[31:20]};

    id_decode_core_regfile #(.WIDTH(WIDTH)) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_load     (bus.load_regfile_i),
        .i_rd       (bus.rd_wr_i),
        .i_wr_data  (bus.wr_data_i),
        .i_rs1      (w_instr[19:15]),
        .i_rs2      (w_instr[24:20]),
        .o_rs1_data (w_rs1_data),
        .o_rs2_data (w_rs2_data)
    );

    id_decode_core_control_rom u_control_rom (
        .i_opcode    (w_instr[6:0]),
        .i_funct3    (w_instr[14:12]),
        .i_funct7_b5 (w_instr[30]),
        .o_ctrl      (w_ctrl)
    );

    assign w_cmp_b = (w_ctrl.cmpmux_sel == CMPMUX_RS2_OUT) ? w_rs2_data : w_i_imm;

    id_decode_core_cmp #(.WIDTH(WIDTH)) u_cmp (
        .i_cmpop (w_ctrl.cmpop),
        .i_a     (w_rs1_data),
        .i_b     (w_cmp_b),
        .o_br_en (w_br_en)
    );

    assign bus.ctrl_word_o = w_ctrl;
    assign bus.rs1_out_o   = w_rs1_data;
    assign bus.rs2_out_o   = w_rs2_data;
    assign bus.br_en_o     = w_br_en;
    assign bus.i_imm_o     = w_i_imm;
    assign bus.s_imm_o     = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign bus.b_imm_o     = {{20{w_instr[31]}}, w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
    assign bus.u_imm_o     = {w_instr[31:12], 12'h000};
    assign bus.j_imm_o     = {{12{w_instr[31]}}, w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
    assign bus.rs1_o       = w_instr[19:15];
    assign bus.rs2_o       = w_instr[24:20];
    assign bus.rd_o        = w_instr[11:7];
endmodule
`default_nettype wire

// File: tb/tb_id_decode_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_decode_core
// Purpose  : Self-checking bench for id_decode_core: control-word vector
//            table, regfile/comparator corner sequences, random stimulus
//            against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_decode_core;
    import rv32i_types::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_decode_core_if bus();
    id_decode_core #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0]       instr;
        rv32i_control_word exp;
    } ctrl_vec_t;
    ctrl_vec_t vecs[$];

    logic [31:0] m_regs [32];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic rv32i_control_word cw(
        input logic [31:0] ins, input alu_ops aluop, input logic [2:0] cmpop,
        input pcmux_sel_t pc, input alumux1_sel_t a1, input alumux2_sel_t a2,
        input regfilemux_sel_t rf, input cmpmux_sel_t cm,
        input logic ld, input logic mr, input logic mw, input logic [3:0] be);
        rv32i_control_word c;
        c.opcode = ins[6:0];  c.aluop = aluop;   c.cmpop = cmpop;
        c.pcmux_sel = pc;     c.alumux1_sel = a1; c.alumux2_sel = a2;
        c.regfilemux_sel = rf; c.cmpmux_sel = cm;
        c.load_regfile = ld;  c.mem_read = mr;   c.mem_write = mw; c.mem_byte_en = be;
        return c;
    endfunction

    task automatic add_vec(input logic [31:0] ins, input rv32i_control_word c);
        ctrl_vec_t v;
        v.instr = ins;
        v.exp   = c;
        vecs.push_back(v);
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] d);
        bus.load_regfile_i = 1'b1;
        bus.rd_wr_i        = r;
        bus.wr_data_i      = d;
        @(posedge clk);
        #1;
        bus.load_regfile_i = 1'b0;
    endtask

    // ---- reference model: immediates via arithmetic shifts of the word ----
    function automatic logic [31:0] ref_i(input logic [31:0] ins);
        int s = int'(ins);
        return 32'(s >>> 20);
    endfunction
    function automatic logic [31:0] ref_s(input logic [31:0] ins);
        int s = int'(ins);
        return 32'((s >>> 25) << 5) | ((ins >> 7) & 32'h1F);
    endfunction
    function automatic logic [31:0] ref_b(input logic [31:0] ins);
        int s = int'(ins);
        return 32'((s >>> 31) << 12) | (((ins >> 7) & 32'h1) << 11) |
               (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1);
    endfunction
    function automatic logic [31:0] ref_j(input logic [31:0] ins);
        int s = int'(ins);
        return 32'((s >>> 31) << 20) | (((ins >> 12) & 32'hFF) << 12) |
               (((ins >> 20) & 32'h1) << 11) | (((ins >> 21) & 32'h3FF) << 1);
    endfunction

    function automatic logic ref_br(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] rs2v);
        logic [6:0]  op = ins[6:0];
        logic [2:0]  f3 = ins[14:12];
        logic [31:0] b;
        if ((op == 7'h13 || op == 7'h33) && (f3 == 3'd2 || f3 == 3'd3)) begin
            b = (op == 7'h13) ? ref_i(ins) : rs2v;
            return (f3 == 3'd2) ? (int'(a) < int'(b)) : (a < b);
        end
        b = rs2v;
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return int'(a) <  int'(b);
            3'd5: return int'(a) >= int'(b);
            3'd6: return a <  b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_rd(input logic [4:0] idx, input logic ld,
                                           input logic [4:0] rd, input logic [31:0] d);
        if (idx == 5'd0) return 32'h0;
        if (ld && rd == idx) return d;
        return m_regs[idx];
    endfunction

    logic [6:0] opcodes [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                 7'h23, 7'h13, 7'h33, 7'h73, 7'h7F};

    initial begin
        // ---------------- control-word vector table ----------------
        add_vec(32'h123450B7, cw(32'h123450B7, ALU_SRL, 3'd5, PCMUX_PC_PLUS4, ALUMUX1_RS1_OUT, ALUMUX2_I_IMM, RFMUX_U_IMM,    CMPMUX_RS2_OUT, 1, 0, 0, 4'b0000));
        add_vec(32'h00001117, cw(32'h00001117, ALU_ADD, 3'd1, PCMUX_PC_PLUS4, ALUMUX1_PC_OUT,  ALUMUX2_U_IMM, RFMUX_ALU_OUT,  CMPMUX_RS2_OUT, 1, 0, 0, 4'b0000));
        add_vec(32'h000000EF, cw(32'h000000EF, ALU_ADD, 3'd0, PCMUX_ALU_OUT,  ALUMUX1_PC_OUT,  ALUMUX2_J_IMM, RFMUX_PC_PLUS4, CMPMUX_RS2_OUT, 1, 0, 0, 4'b0000));
        add_vec(32'h00008067, cw(32'h00008067, ALU_ADD, 3'd0, PCMUX_ALU_MOD2, ALUMUX1_RS1_OUT, ALUMUX2_I_IMM, RFMUX_PC_PLUS4, CMPMUX_RS2_OUT, 1, 0, 0, 4'b0000));
        add_vec(32'h00208063, cw(32'h00208063, ALU_ADD, 3'd0, PCMUX_PC_PLUS4, ALUMUX1_PC_OUT,  ALUMUX2_B_IMM, RFMUX_ALU_OUT,  CMPMUX_RS2_OUT, 0, 0, 0, 4'b0000));
        add_vec(32'h0020F063, cw(32'h0020F063, ALU_ADD, 3'd7, PCMUX_PC_PLUS4, ALUMUX1_PC_OUT,  ALUMUX2_B_IMM, RFMUX_ALU_OUT,  CMPMUX_RS2_OUT, 0, 0, 0, 4'b0000));
        add_vec(32'h0000D183, cw(32'h0000D183, ALU_ADD, 3'd5, PCMUX_PC_PLUS4, ALUMUX1_RS1_OUT, ALUMUX2_I_IMM, RFMUX_LHU,      CMPMUX_RS2_OUT, 1, 1, 0, 4'b0000));
        add_vec(32'h00008183, cw(32'h00008183, ALU_ADD, 3'd0, PCMUX_PC_PLUS4, ALUMUX1_RS1_OUT, ALUMUX2_I_IMM, RFMUX_LB,       CMPMUX_RS2_OUT, 1, 1, 0, 4'b0000));
        add_vec(32'h0000A183, cw(32'h0000A183, ALU_ADD, 3'd2, PCMUX_PC_PLUS4, ALUMUX1_RS1_OUT, ALUMUX2_I_IMM, RFMUX_LW,       CMPMUX_RS2_OUT, 1, 1, 0, 4'b0000));
        add_vec(32'h00209023, cw(32'h00209023, ALU_ADD, 3'd1, PCMUX_PC_PLUS4, ALUMUX1_RS1_OUT, ALUMUX2_S_IMM, RFMUX_ALU_OUT,  CMPMUX_RS2_OUT, 0, 0, 1, 4'b0011));
        add_vec(32'h0020A023, cw(32'h0020A023, ALU_ADD, 3'd2, PCMUX_PC_PLUS4, ALUMUX1_RS1_OUT, ALUMUX2_S_IMM, RFMUX_ALU_OUT,  CMPMUX_RS2_OUT, 0, 0, 1, 4'b1111));
        add_vec(32'h00208023, cw(32'h00208023, ALU_ADD, 3'd0, PCMUX_PC_PLUS4, ALUMUX1_RS1_OUT, ALUMUX2_S_IMM, RFMUX_ALU_OUT,  CMPMUX_RS2_OUT, 0, 0, 1, 4'b0001));
        add_vec(32'hFFF0A193, cw(32'hFFF0A193, ALU_SRA, 3'd4, PCMUX_PC_PLUS4, ALUMUX1_RS1_OUT, ALUMUX2_I_IMM, RFMUX_BR_EN,    CMPMUX_I_IMM,   1, 0, 0, 4'b0000));
        add_vec(32'hFFF0B193, cw(32'hFFF0B193, ALU_SUB, 3'd6, PCMUX_PC_PLUS4, ALUMUX1_RS1_OUT, ALUMUX2_I_IMM, RFMUX_BR_EN,    CMPMUX_I_IMM,   1, 0, 0, 4'b0000));
        add_vec(32'h4040D193, cw(32'h4040D193, ALU_SRA, 3'd5, PCMUX_PC_PLUS4, ALUMUX1_RS1_OUT, ALUMUX2_I_IMM, RFMUX_ALU_OUT,  CMPMUX_RS2_OUT, 1, 0, 0, 4'b0000));
        add_vec(32'h0040D193, cw(32'h0040D193, ALU_SRL, 3'd5, PCMUX_PC_PLUS4, ALUMUX1_RS1_OUT, ALUMUX2_I_IMM, RFMUX_ALU_OUT,  CMPMUX_RS2_OUT, 1, 0, 0, 4'b0000));
        add_vec(32'h0040C193, cw(32'h0040C193, ALU_XOR, 3'd4, PCMUX_PC_PLUS4, ALUMUX1_RS1_OUT, ALUMUX2_I_IMM, RFMUX_ALU_OUT,  CMPMUX_RS2_OUT, 1, 0, 0, 4'b0000));
        add_vec(32'h402081B3, cw(32'h402081B3, ALU_SUB, 3'd0, PCMUX_PC_PLUS4, ALUMUX1_RS1_OUT, ALUMUX2_RS2_OUT, RFMUX_ALU_OUT, CMPMUX_RS2_OUT, 1, 0, 0, 4'b0000));
        add_vec(32'h002081B3, cw(32'h002081B3, ALU_ADD, 3'd0, PCMUX_PC_PLUS4, ALUMUX1_RS1_OUT, ALUMUX2_RS2_OUT, RFMUX_ALU_OUT, CMPMUX_RS2_OUT, 1, 0, 0, 4'b0000));
        add_vec(32'h0020B1B3, cw(32'h0020B1B3, ALU_SUB, 3'd6, PCMUX_PC_PLUS4, ALUMUX1_RS1_OUT, ALUMUX2_RS2_OUT, RFMUX_BR_EN,   CMPMUX_RS2_OUT, 1, 0, 0, 4'b0000));
        add_vec(32'h4020D1B3, cw(32'h4020D1B3, ALU_SRA, 3'd5, PCMUX_PC_PLUS4, ALUMUX1_RS1_OUT, ALUMUX2_RS2_OUT, RFMUX_ALU_OUT, CMPMUX_RS2_OUT, 1, 0, 0, 4'b0000));
        add_vec(32'h00000073, cw(32'h00000073, ALU_ADD, 3'd0, PCMUX_PC_PLUS4, ALUMUX1_RS1_OUT, ALUMUX2_I_IMM, RFMUX_ALU_OUT,  CMPMUX_RS2_OUT, 0, 0, 0, 4'b0000));
        add_vec(32'h00002073, cw(32'h00002073, ALU_ADD, 3'd2, PCMUX_PC_PLUS4, ALUMUX1_RS1_OUT, ALUMUX2_I_IMM, RFMUX_ALU_OUT,  CMPMUX_RS2_OUT, 0, 0, 0, 4'b0000));
        add_vec(32'h0000007F, cw(32'h0000007F, ALU_ADD, 3'd0, PCMUX_PC_PLUS4, ALUMUX1_RS1_OUT, ALUMUX2_I_IMM, RFMUX_ALU_OUT,  CMPMUX_RS2_OUT, 0, 0, 0, 4'b0000));

        bus.instr_i = '0; bus.load_regfile_i = 1'b0; bus.rd_wr_i = '0; bus.wr_data_i = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // ---------------- reset state ----------------
        for (int i = 1; i < 32; i++) begin
            bus.instr_i = (32'(i) << 15) | (32'(i) << 20);
            #1;
            check($sformatf("reset_x%0d", i), bus.rs1_out_o, 32'h0);
        end

        // ---------------- x0 is never written ----------------
        wr(5'd0, 32'hDEADBEEF);
        bus.instr_i = 32'h0;
        #1 check("x0_read", bus.rs1_out_o, 32'h0);

        // ---------------- write-through then persistence ----------------
        bus.instr_i = 32'(5) << 15;
        bus.load_regfile_i = 1'b1; bus.rd_wr_i = 5'd5; bus.wr_data_i = 32'h12345678;
        #1 check("wt_before_edge", bus.rs1_out_o, 32'h12345678);
        @(posedge clk); #1;
        bus.load_regfile_i = 1'b0; bus.wr_data_i = 32'h0;
        #1 check("wt_after_edge", bus.rs1_out_o, 32'h12345678);

        // ---------------- asynchronous clear ----------------
        rst = 1'b0;
        #1 check("async_rst", bus.rs1_out_o, 32'h0);
        rst = 1'b1;
        #1;

        // ---------------- control-word table ----------------
        foreach (vecs[i]) begin
            bus.instr_i = vecs[i].instr;
            #1 check($sformatf("ctrl[%0d]_%h", i, vecs[i].instr), bus.ctrl_word_o, vecs[i].exp);
        end

        // ---------------- comparator corners ----------------
        wr(5'd1, 32'd7); wr(5'd2, 32'd7);
        bus.instr_i = 32'h00208063; #1 check("beq_eq", bus.br_en_o, 1'b1);
        bus.instr_i = 32'h00209063; #1 check("bne_eq", bus.br_en_o, 1'b0);
        wr(5'd1, 32'hFFFFFFFF); wr(5'd2, 32'd1);
        bus.instr_i = 32'h0020C063; #1 check("blt_neg", bus.br_en_o, 1'b1);
        bus.instr_i = 32'h0020E063; #1 check("bltu_big", bus.br_en_o, 1'b0);
        bus.instr_i = 32'h0020D063; #1 check("bge_neg", bus.br_en_o, 1'b0);
        bus.instr_i = 32'h0020F063; #1 check("bgeu_big", bus.br_en_o, 1'b1);
        wr(5'd1, 32'hFFFFFFFE);
        bus.instr_i = 32'hFFF0A193;
        #1;
        check("slti_br_en", bus.br_en_o, 1'b1);
        check("slti_cmpmux", bus.ctrl_word_o.cmpmux_sel, CMPMUX_I_IMM);
        check("slti_rfmux", bus.ctrl_word_o.regfilemux_sel, RFMUX_BR_EN);
        // beq x0,x0,-4
        bus.instr_i = 32'hFE000EE3;
        #1;
        check("b_imm_neg4", bus.b_imm_o, 32'hFFFFFFFC);
        check("beq_x0_x0", bus.br_en_o, 1'b1);

        // ---------------- random against model ----------------
        rst = 1'b0; #1 rst = 1'b1;
        for (int k = 0; k < 32; k++) m_regs[k] = 32'h0;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins, d, a, b;
            logic        ld;
            logic [4:0]  rd;
            ld  = 1'($urandom_range(0, 1));
            rd  = 5'($urandom_range(0, 7));
            d   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
            ins = 32'($urandom);
            ins[6:0]   = opcodes[$urandom_range(0, 10)];
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            bus.instr_i = ins; bus.load_regfile_i = ld; bus.rd_wr_i = rd; bus.wr_data_i = d;
            #1;
            a = ref_rd(ins[19:15], ld, rd, d);
            b = ref_rd(ins[24:20], ld, rd, d);
            check("rnd_rs1_out", bus.rs1_out_o, a);
            check("rnd_rs2_out", bus.rs2_out_o, b);
            check("rnd_i_imm", bus.i_imm_o, ref_i(ins));
            check("rnd_s_imm", bus.s_imm_o, ref_s(ins));
            check("rnd_b_imm", bus.b_imm_o, ref_b(ins));
            check("rnd_u_imm", bus.u_imm_o, ins & 32'hFFFFF000);
            check("rnd_j_imm", bus.j_imm_o, ref_j(ins));
            check("rnd_br_en", bus.br_en_o, ref_br(ins, a, b));
            check("rnd_idx", {bus.rs1_o, bus.rs2_o, bus.rd_o}, {ins[19:15], ins[24:20], ins[11:7]});
            @(posedge clk); #1;
            if (ld && rd != 5'd0) m_regs[rd] = d;
        end
        bus.load_regfile_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
